// File: rtl/melody_sequencer_if.sv
// Control/status bundle between user logic (master) and the melody sequencer (slave).
// Carries note-table writes, playback control and the tone-generator drive outputs.
interface melody_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 15,
  parameter int DUR_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DIV_W-1:0] wr_div;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      len;
  logic             loop;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [AW-1:0]    note_idx;
  logic [DIV_W-1:0] tone_div;
  logic             tone_en;

  modport master (
    output wr_en, wr_addr, wr_div, wr_dur, len, loop, start, stop,
    input  busy, done, note_idx, tone_div, tone_en
  );

  modport slave (
    input  wr_en, wr_addr, wr_div, wr_dur, len, loop, start, stop,
    output busy, done, note_idx, tone_div, tone_en
  );
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a programmable (divider, duration) note table and
// drives a square-wave tone generator, with an optional silent gap after each note,
// one-shot or looped playback and start/stop control. All outputs are registered.
module melody_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 15,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  melody_sequencer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] tone_div_q, tone_div_d;
  logic             tone_en_q, tone_en_d;
  logic [DIV_W-1:0] table_div_q [DEPTH];
  logic [DIV_W-1:0] table_div_d [DEPTH];
  logic [DUR_W-1:0] table_dur_q [DEPTH];
  logic [DUR_W-1:0] table_dur_d [DEPTH];

  logic             tick_s;
  logic             advance_s;
  logic             last_s;
  logic             load_s;
  logic [AW-1:0]    load_idx_s;
  logic [DIV_W-1:0] ld_div_s;
  logic [DUR_W-1:0] ld_dur_s;

  assign tick_s = (presc_q == PW'(TICK_DIV - 1));
  assign last_s = !({1'b0, idx_q} < (len_q - LW'(1)));

  // Next-state logic: table writes, phase sequencing, advance and note loading.
  always_comb begin
    state_d    = state_q;
    presc_d    = tick_s ? '0 : (presc_q + PW'(1));
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tone_div_d = tone_div_q;
    tone_en_d  = tone_en_q;
    advance_s  = 1'b0;
    load_s     = 1'b0;
    load_idx_s = '0;

    // Writes land at the clock edge, so a same-cycle load still sees the old entry.
    if (bus.wr_en) begin
      table_div_d = table_div_q;
      table_dur_d = table_dur_q;
      table_div_d[bus.wr_addr] = bus.wr_div;
      table_dur_d[bus.wr_addr] = bus.wr_dur;
    end else begin
      table_div_d = table_div_q;
      table_dur_d = table_dur_q;
    end

    if (bus.stop) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      tone_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            len_d      = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
            busy_d     = 1'b1;
            load_s     = 1'b1;
            load_idx_s = '0;
          end else begin
            busy_d = 1'b0;
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            if (dur_cnt_q <= DUR_W'(1)) begin
              if (GAP_TICKS > 0) begin
                state_d   = ST_GAP;
                tone_en_d = 1'b0;
                gap_cnt_d = GW'(GAP_TICKS);
                presc_d   = '0;
              end else begin
                advance_s = 1'b1;
              end
            end else begin
              dur_cnt_d = dur_cnt_q - DUR_W'(1);
            end
          end else begin
            dur_cnt_d = dur_cnt_q;
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            if (gap_cnt_q <= GW'(1)) begin
              advance_s = 1'b1;
            end else begin
              gap_cnt_d = gap_cnt_q - GW'(1);
            end
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          tone_en_d = 1'b0;
        end
      endcase

      // End of a note (and its gap): next entry, wrap for looping, or finish the pass.
      if (advance_s && !last_s) begin
        load_s     = 1'b1;
        load_idx_s = idx_q + AW'(1);
      end else if (advance_s && bus.loop) begin
        load_s     = 1'b1;
        load_idx_s = '0;
      end else if (advance_s) begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        tone_en_d = 1'b0;
        done_d    = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end

    // Loading a note restarts the prescaler so its first tick is TICK_DIV cycles away.
    ld_div_s   = table_div_q[load_idx_s];
    ld_dur_s   = (table_dur_q[load_idx_s] == '0) ? DUR_W'(1) : table_dur_q[load_idx_s];
    state_d    = load_s ? ST_PLAY : state_d;
    idx_d      = load_s ? load_idx_s : idx_d;
    tone_div_d = load_s ? ld_div_s : tone_div_d;
    tone_en_d  = load_s ? (ld_div_s != '0) : tone_en_d;
    dur_cnt_d  = load_s ? ld_dur_s : dur_cnt_d;
    presc_d    = load_s ? '0 : presc_d;
  end

  // State, counters, outputs and note table registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      dur_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tone_div_q  <= '0;
      tone_en_q   <= 1'b0;
      table_div_q <= '{default: '0};
      table_dur_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      dur_cnt_q   <= dur_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tone_div_q  <= tone_div_d;
      tone_en_q   <= tone_en_d;
      table_div_q <= table_div_d;
      table_dur_q <= table_dur_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
  assign bus.tone_div = tone_div_q;
  assign bus.tone_en  = tone_en_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a note-level reference model expands each note into its
// expected per-cycle outputs; a monitor compares DUT outputs against a scoreboard queue.
module tb_melody_sequencer;
  localparam int T     = 4;
  localparam int G     = 1;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV_W = 15;
  localparam int DUR_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  melody_sequencer_if #(.DEPTH(DEPTH), .DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

  melody_sequencer #(
    .TICK_DIV(T), .DEPTH(DEPTH), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_TICKS(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic             busy;
    logic             done;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [AW-1:0]    idx;
    bit               full;
  } exp_t;

  exp_t sb_q[$];
  exp_t note_q[$];

  logic [DIV_W-1:0] m_div [DEPTH];
  logic [DUR_W-1:0] m_dur [DEPTH];
  bit m_active = 1'b0;
  int m_idx = 0;
  int m_len = 0;
  int n_tests = 0;
  int n_fail = 0;

  function automatic exp_t mk(logic b, logic d, logic e, logic [DIV_W-1:0] dv,
                              logic [AW-1:0] ix, bit f);
    exp_t r;
    r.busy = b; r.done = d; r.en = e; r.div = dv; r.idx = ix; r.full = f;
    return r;
  endfunction

  // A note sounds for dur*T cycles (dur 0 counts as 1), then stays silent for G*T cycles.
  task automatic expand(int i);
    logic [DIV_W-1:0] dv;
    int d;
    dv = m_div[i];
    d  = (m_dur[i] == '0) ? 1 : int'(m_dur[i]);
    for (int c = 0; c < d * T; c++) note_q.push_back(mk(1'b1, 1'b0, dv != '0, dv, AW'(i), 1'b0));
    for (int c = 0; c < G * T; c++) note_q.push_back(mk(1'b1, 1'b0, 1'b0, dv, AW'(i), 1'b0));
  endtask

  // Predict the outputs of the cycle after the one whose inputs are currently driven.
  task automatic model_step();
    exp_t e;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin m_div[k] = '0; m_dur[k] = '0; end
      note_q.delete();
      m_active = 1'b0;
      e = mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    end else if (bus.stop) begin
      note_q.delete();
      m_active = 1'b0;
      e = mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end else if (m_active) begin
      if (note_q.size() == 0) begin
        if (m_idx < m_len - 1) begin
          m_idx++;
          expand(m_idx);
          e = note_q.pop_front();
        end else if (bus.loop) begin
          m_idx = 0;
          expand(0);
          e = note_q.pop_front();
        end else begin
          m_active = 1'b0;
          e = mk(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        end
      end else begin
        e = note_q.pop_front();
      end
    end else if (bus.start && bus.len != '0) begin
      m_len    = (int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
      m_idx    = 0;
      m_active = 1'b1;
      expand(0);
      e = note_q.pop_front();
    end else begin
      e = mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    if (!rst && bus.wr_en) begin
      m_div[bus.wr_addr] = bus.wr_div;
      m_dur[bus.wr_addr] = bus.wr_dur;
    end
    sb_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(int a, int dv, int du);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_div  = DIV_W'(dv);
    bus.wr_dur  = DUR_W'(du);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic kick(int l, logic lp);
    bus.len   = 5'(l);
    bus.loop  = lp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic finish_pass();
    for (int k = 0; k < 3000 && m_active; k++) step();
  endtask

  // Monitor: compare every cycle's outputs against the oldest prediction.
  initial begin
    exp_t e;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        bad = (bus.busy !== e.busy) || (bus.done !== e.done) || (bus.tone_en !== e.en);
        if (e.full || e.busy)
          bad = bad || (bus.tone_div !== e.div) || (bus.note_idx !== e.idx);
        if (bad) begin
          n_fail++;
          $display("FAIL outputs t=%0t got busy=%b done=%b en=%b div=%0d idx=%0d expected busy=%b done=%b en=%b div=%0d idx=%0d",
                   $time, bus.busy, bus.done, bus.tone_en, bus.tone_div, bus.note_idx,
                   e.busy, e.done, e.en, e.div, e.idx);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dur = '0;
    bus.len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(2);

    // One-shot three-note pass with a rest in the middle.
    wr(0, 100, 2); wr(1, 0, 1); wr(2, 200, 3);
    kick(3, 1'b0);
    run(45);

    // Stop mid-note, then restart from entry 0.
    kick(3, 1'b0);
    run(4);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    run(5);
    kick(3, 1'b0);
    run(40);

    // Looping single note, then drop loop so the pass ends with done.
    wr(0, 50, 1);
    kick(1, 1'b1);
    run(22);
    bus.loop = 1'b0;
    run(12);

    // Ignored starts: len=0, start with stop, start while busy.
    kick(0, 1'b0); run(3);
    bus.stop = 1'b1; kick(1, 1'b0); bus.stop = 1'b0; run(3);
    kick(3, 1'b0); run(6);
    kick(2, 1'b0); finish_pass(); run(2);

    // Full table with len clamped to DEPTH; some zero durations.
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 999), $urandom_range(0, 2));
    wr(5, 321, 0);
    kick(20, 1'b0); finish_pass(); run(2);

    // Rewrite entry 3 while entry 2 plays.
    wr(2, 123, 2); wr(3, 77, 1);
    kick(4, 1'b0);
    for (int k = 0; k < 200 && m_idx != 2; k++) step();
    wr(3, 555, 2);
    finish_pass(); run(2);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      bus.wr_en   = ($urandom_range(0, 4) == 0);
      bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_div  = ($urandom_range(0, 3) == 0) ? '0 : DIV_W'($urandom_range(1, 32767));
      bus.wr_dur  = DUR_W'($urandom_range(0, 3));
      bus.len     = 5'($urandom_range(0, 20));
      bus.loop    = ($urandom_range(0, 3) == 0);
      bus.start   = ($urandom_range(0, 9) == 0);
      bus.stop    = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0; bus.loop = 1'b0;
    finish_pass(); run(2);

    // Reset during playback clears the table: entry 0 then plays as a silent rest.
    wr(0, 900, 3); wr(1, 800, 2);
    kick(2, 1'b0);
    run(6);
    rst = 1'b1; step(); rst = 1'b0;
    kick(1, 1'b0);
    finish_pass();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    run(3);

    repeat (2) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
